// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package cla_seq_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : cla_seq_pkg

// File: rtl/cla_64.sv
// 64-bit two-level carry look-ahead adder: 4-bit groups with in-group
// look-ahead, group generate/propagate combined across the 16 groups.
module cla_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [16:0] grp_c;

    // Bit and group generate/propagate, group carries, then per-bit carries and sum.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        for (int i = 0; i < 16; i++) begin
            grp_g[i] = g[4*i+3]
                     | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            grp_p[i] = &p[4*i +: 4];
        end
        grp_c[0] = cin;
        for (int i = 0; i < 16; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
        for (int i = 0; i < 16; i++) begin
            c[4*i]   = grp_c[i];
            c[4*i+1] = g[4*i] | (p[4*i] & grp_c[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & grp_c[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & grp_c[i]);
        end
        c[64] = grp_c[16];
        sum   = p ^ c[63:0];
        cout  = c[64];
    end

endmodule : cla_64

// File: rtl/cla_wide_add_seq.sv
// Multi-precision add/subtract: one 64-bit word per clock through a shared
// cla_64, least significant word first, with the word carry registered.
module cla_wide_add_seq
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_sub,
    input  logic                    cin,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);

    localparam int TOT_W = WORD_W * WORDS;
    localparam int K_W   = $clog2(WORDS);
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    state_t              state;
    state_t              next_state;
    logic [TOT_W-1:0]    a_q;
    logic [TOT_W-1:0]    b_q;
    logic                c_q;
    logic [K_W-1:0]      k;
    logic [WORD_W-1:0]   a_word;
    logic [WORD_W-1:0]   b_word;
    logic [WORD_W-1:0]   sum_word;
    logic                add_cout;
    logic                last_word;
    logic                msb_carry;
    logic                busy_next;
    logic                done_next;

    // Select the current word of each operand and flag the final word.
    always_comb begin
        a_word    = a_q[WORD_W*int'(k) +: WORD_W];
        b_word    = b_q[WORD_W*int'(k) +: WORD_W];
        last_word = (k == K_LAST);
        // Carry into the top bit, recovered from the top word's sum bit.
        msb_carry = a_q[TOT_W-1] ^ b_q[TOT_W-1] ^ sum_word[WORD_W-1];
    end

    cla_64 u_cla (
        .a    (a_word),
        .b    (b_word),
        .cin  (c_q),
        .sum  (sum_word),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a start during RUN is deliberately ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
                else       next_state = IDLE;
            end
            RUN: begin
                if (last_word) next_state = DONE;
                else           next_state = RUN;
            end
            DONE: begin
                if (start) next_state = RUN;
                else       next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done come out of flops.
    always_comb begin
        busy_next = (next_state == RUN);
        done_next = (next_state == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Operand capture, word carry, word index and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= 1'b0;
            k    <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= (op_sub == OP_SUB) ? ~b : b;
                        c_q  <= (op_sub == OP_ADD) ? cin : 1'b1;
                        k    <= '0;
                        sum  <= '0;
                        cout <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[WORD_W*int'(k) +: WORD_W] <= sum_word;
                    c_q <= add_cout;
                    if (last_word) begin
                        cout <= add_cout;
                        ovf  <= msb_carry ^ add_cout;
                        k    <= '0;
                    end else begin
                        k    <= k + 1'b1;
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule : cla_wide_add_seq

// File: tb/tb_cla_wide_add_seq.sv
// Randomised and directed bench for cla_wide_add_seq against a plain
// arithmetic model of multi-precision add/subtract.
module tb_cla_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 64 * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;

    cla_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: full-width arithmetic, signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         input logic mcin, output logic [W-1:0] msum, output logic mcout,
                         output logic movf);
        logic [W:0] full;
        if (!msub) begin
            full  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            msum  = full[W-1:0];
            mcout = full[W];
            movf  = (ma[W-1] == mb[W-1]) && (msum[W-1] != ma[W-1]);
        end else begin
            msum  = ma - mb;
            mcout = (ma >= mb);
            movf  = (ma[W-1] != mb[W-1]) && (msum[W-1] != ma[W-1]);
        end
    endtask

    // Scramble inputs after a start edge; the DUT must not depend on them.
    task automatic scramble();
        a      = rand_w();
        b      = rand_w();
        op_sub = 1'($urandom_range(0, 1));
        cin    = 1'($urandom_range(0, 1));
    endtask

    // Wait for done, counting negedges since the start edge and busy cycles.
    task automatic wait_done(output int n, output int busy_cnt);
        bit got;
        n = 0; busy_cnt = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                         input logic tcin, input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n, bc;
        model(ta, tb, tsub, tcin, es, ec, eo);
        @(negedge clk);
        a = ta; b = tb; op_sub = tsub; cin = tcin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        wait_done(n, bc);
        check({tag, "_latency"}, W'(n), W'(WORDS + 1));
        check({tag, "_busy"}, W'(bc), W'(WORDS));
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, W'(cout), W'(ec));
        check({tag, "_ovf"}, W'(ovf), W'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, W'(done), W'(0));
        check({tag, "_hold"}, sum, es);
    endtask

    initial begin
        logic [W-1:0] ones, top, ra, rb, es, es2;
        logic         ec, eo, ec2, eo2;
        int           n, bc, done_seen;

        checks = 0; errors = 0;
        ones = '1;
        top  = '0; top[W-1] = 1'b1;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #23;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_sum", sum, W'(0));
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the arithmetic corner list.
        do_op(ones, ones, 1'b0, 1'b0, "full_ones");
        check("full_ones_const", sum, ones - W'(1));
        do_op(ones, W'(1), 1'b0, 1'b0, "ripple");
        check("ripple_const", sum, W'(0));
        do_op(W'(0), W'(0), 1'b0, 1'b1, "cin_only");
        check("cin_only_const", sum, W'(1));
        do_op(W'(5), W'(7), 1'b1, 1'b0, "sub_borrow");
        check("sub_borrow_const", sum, ones - W'(1));
        do_op(W'(7), W'(5), 1'b1, 1'b1, "sub_noborrow");
        check("sub_noborrow_const", sum, W'(2));
        do_op(~top, W'(1), 1'b0, 1'b0, "ovf_pos");
        check("ovf_pos_flag", W'(ovf), W'(1));
        do_op(top, ones, 1'b0, 1'b0, "ovf_neg");
        check("ovf_neg_flag", W'(ovf), W'(1));
        do_op(top, W'(1), 1'b1, 1'b0, "ovf_sub");

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            do_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        // Start during RUN must be ignored.
        ra = rand_w(); rb = rand_w();
        model(ra, rb, 1'b0, 1'b1, es, ec, eo);
        @(negedge clk);
        a = ra; b = rb; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); @(negedge clk);
        scramble(); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (n < 40 && !done) begin
            @(negedge clk);
            n++;
        end
        check("run_start_sum", sum, es);
        check("run_start_cout", W'(cout), W'(ec));
        check("run_start_ovf", W'(ovf), W'(eo));

        // Back-to-back: start asserted in the DONE cycle.
        ra = rand_w(); rb = rand_w();
        model(ra, rb, 1'b1, 1'b0, es2, ec2, eo2);
        a = ra; b = rb; op_sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; scramble();
        @(negedge clk);
        check("b2b_cleared", sum, W'(0));
        check("b2b_busy", W'(busy), W'(1));
        n = 1;
        while (n < 40 && !done) begin
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", W'(n), W'(WORDS + 1));
        check("b2b_sum", sum, es2);
        check("b2b_cout", W'(cout), W'(ec2));
        check("b2b_ovf", W'(ovf), W'(eo2));
        @(negedge clk);

        // Asynchronous reset while k is 2.
        @(negedge clk);
        a = ones; b = ones; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_sum", sum, W'(0));
        check("mid_rst_cout", W'(cout), W'(0));
        check("mid_rst_ovf", W'(ovf), W'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("mid_rst_quiet", W'(done_seen), W'(0));
        do_op(W'(3), W'(4), 1'b0, 1'b0, "after_rst");
        check("after_rst_const", sum, W'(7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cla_wide_add_seq
